card_rand_gen: RTL and testbench
================================

# card_rand_gen

Parametrised successor to the 4-bit XNOR LFSR. The core is a configurable-width XNOR LFSR that free-runs every clock, so the user's button timing supplies the entropy. On request, the block rejection-samples the LFSR into NUM_CARDS card values in 1..MAX_VAL. It presents them on a valid/ack handshake to the 24-game puzzle loader.

## Interface
- WIDTH, 4, LFSR width. Supported values: 4, 8, 16.
- NUM_CARDS, 4, cards per draw (≥1).
- MAX_VAL, 13, highest card value (≥1).
- VAL_W, derived as $clog2(MAX_VAL+1), card field width. Must be ≤ WIDTH. If VAL_W == WIDTH, MAX_VAL must be ≤ 2^WIDTH−2.
- clk  in  1  system clock. Single clock domain.
- rst  in  1  reset. Synchronous and active-high.
- seed_ld  in  1  load `seed` into the LFSR. Honoured in IDLE and DONE only.
- seed  in  WIDTH  seed value.
- req  in  1  start a draw.
- ack  in  1  consumer has taken `cards`.
- cards  out  NUM_CARDS*VAL_W  slot k occupies bits [k*VAL_W +: VAL_W].
- valid  out  1  `cards` is complete and stable.
- busy  out  1  a draw is in progress.
- rand_out  out  WIDTH  raw LFSR state.

## Operation
- LFSR step: lfsr <= {lfsr[WIDTH-2:0], fb}. fb is the XNOR-reduction of the tap bits.
  - Taps are 4: {3,2}; 8: {7,5,4,3}; 16: {15,14,12,3}. All are maximal length.
  - All-ones is the lockup state and is never entered.
- The LFSR steps on every clock, except on a cycle where rst is high or a seed load is honoured.
- Seed load: lfsr <= seed. If seed is all-ones, load all-zeros instead.
- FSM states: IDLE, DRAW, DONE.
  - IDLE: req=1 → DRAW, slot index k <= 0.
  - DRAW: each cycle, cand = lfsr[VAL_W-1:0] (the pre-step value).
    - If 1 ≤ cand ≤ MAX_VAL: write cand to slot k and increment k.
    - Otherwise, reject the candidate; k is unchanged.
    - When slot NUM_CARDS−1 is written → DONE.
    - req and seed_ld are ignored in DRAW.
  - DONE: valid=1, cards held.
    - ack=1 with req=0 → IDLE.
    - ack=1 with req=1 → DRAW with k=0; cards are overwritten progressively.
    - ack=0 → remain in DONE; a new req is ignored.
- seed_ld and req in the same IDLE/DONE cycle: the seed is loaded and the draw starts. The first candidate is the loaded seed (or zero for an all-ones seed).
- Cards may repeat; no uniqueness filter.
- Draw termination is guaranteed: every nonzero VAL_W pattern appears within 2^WIDTH−1 steps of a maximal LFSR.

## Timing
- Reset values: lfsr=0, state=IDLE, k=0, cards=0, valid=0, busy=0. rand_out=0.
- rst high mid-draw aborts the draw. All state returns to reset values on that edge.
- busy=1 exactly while in DRAW. valid=1 exactly while in DONE.
- Draw latency: from the edge that samples req, valid rises after NUM_CARDS + (rejections) further edges. Best case is NUM_CARDS.
- cards is registered. Unwritten slots keep their prior values during DRAW.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.

## Structure
- Package rand_pkg:
  - state enum {IDLE, DRAW, DONE}.
  - function tap_mask(width) returning the XNOR tap vector for 4/8/16.
  - Elaboration check rejecting any other width.
- Sub-module lfsr_core (WIDTH): clk, rst, step, ld, seed → state. Contains the lockup guard on load.
- card_rand_gen contains the FSM, slot counter, candidate compare, and card register.

## Test plan
- Sequence (WIDTH=4): release reset, then hold req=0. rand_out must follow 0,1,3,7,14,13,11,6,12,9,2,5,10,4,8,0 (period 15). 15 never appears.
- Draw from reset: req=1 in the first cycle after reset, which steps lfsr to 1 on the sampling edge. Candidates are 1,3,7,14(reject),13. Require valid after 5 DRAW cycles, cards={13,7,3,1} (slot3..slot0), busy=1 for exactly 5 cycles.
- Seed and request together: seed_ld=1, seed=6, req=1 in IDLE. Candidates 6,12,9,2. Require cards={2,9,12,6} and valid after 4 cycles with no rejection.
- Lockup guard: seed_ld with seed=4'b1111 → rand_out=0 next cycle. Then 1,3,… follows.
- Handshake: hold ack=0 for 10 cycles in DONE while pulsing req. Require cards and valid stable. Then ack=1 with req=1 → busy next cycle, valid=0.
- Reset mid-draw: assert rst on the second DRAW cycle. Require valid=0, busy=0, cards=0, rand_out=0 the next cycle. A fresh draw then reproduces the "draw from reset" result.

Source files
------------

// File: rtl/rand_pkg.sv
// rtl/rand_pkg.sv - shared types and LFSR tap table for card_rand_gen
package rand_pkg;

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  // XNOR tap vectors for the maximal-length widths we support
  function automatic logic [15:0] tap_mask(input int width);
    case (width)
      4:       return 16'h000C;
      8:       return 16'h00B8;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic bit width_ok(input int width);
    return (width == 4) || (width == 8) || (width == 16);
  endfunction

endpackage

// File: rtl/card_rand_gen_if.sv
// rtl/card_rand_gen_if.sv - request/ack bundle between card_rand_gen and the puzzle loader
interface card_rand_gen_if #(
  parameter int WIDTH     = 4,
  parameter int NUM_CARDS = 4,
  parameter int MAX_VAL   = 13
);
  localparam int VAL_W = $clog2(MAX_VAL + 1);

  logic                       seed_ld;
  logic [WIDTH-1:0]           seed;
  logic                       req;
  logic                       ack;
  logic [NUM_CARDS*VAL_W-1:0] cards;
  logic                       valid;
  logic                       busy;
  logic [WIDTH-1:0]           rand_out;

  modport master (
    output seed_ld, seed, req, ack,
    input  cards, valid, busy, rand_out
  );

  modport slave (
    input  seed_ld, seed, req, ack,
    output cards, valid, busy, rand_out
  );
endinterface

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - free-running XNOR LFSR with seed load and lockup guard
module lfsr_core
  import rand_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             ld,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(tap_mask(WIDTH));

  logic fb;

  assign fb = ~^(state & TAPS);

  // All-ones is the XNOR lockup state, so a seed of all-ones maps to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= '0;
    end else if (ld) begin
      state <= (&seed) ? '0 : seed;
    end else if (step) begin
      state <= {state[WIDTH-2:0], fb};
    end
  end

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("lfsr_core: WIDTH must be 4, 8 or 16");
  end

endmodule

// File: rtl/card_rand_gen.sv
// rtl/card_rand_gen.sv - rejection-samples the LFSR into NUM_CARDS values in 1..MAX_VAL
module card_rand_gen
  import rand_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int NUM_CARDS = 4,
  parameter int MAX_VAL   = 13
) (
  input  logic            clk,
  input  logic            rst,
  card_rand_gen_if.slave  bus
);

  localparam int VAL_W = $clog2(MAX_VAL + 1);
  localparam int KW    = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1;

  state_t                     state_q, state_d;
  logic [KW-1:0]              k_q, k_d;
  logic [NUM_CARDS*VAL_W-1:0] cards_q;
  logic [WIDTH-1:0]           lfsr;
  logic [VAL_W-1:0]           cand;
  logic                       hit;
  logic                       wr;
  logic                       ld;

  // Seed loads are only honoured outside a draw so a draw sees one continuous stream
  assign ld   = bus.seed_ld && (state_q != DRAW);
  assign cand = lfsr[VAL_W-1:0];
  assign hit  = (cand != '0) && (cand <= VAL_W'(MAX_VAL));

  lfsr_core #(.WIDTH(WIDTH)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (1'b1),
    .ld    (ld),
    .seed  (bus.seed),
    .state (lfsr)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    wr      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          state_d = DRAW;
          k_d     = '0;
        end
      end
      DRAW: begin
        if (hit) begin
          wr = 1'b1;
          if (k_q == KW'(NUM_CARDS - 1)) begin
            state_d = DONE;
            k_d     = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.ack) begin
          state_d = bus.req ? DRAW : IDLE;
          k_d     = '0;
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      cards_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (wr) begin
        cards_q[k_q*VAL_W +: VAL_W] <= cand;
      end
    end
  end

  assign bus.cards    = cards_q;
  assign bus.valid    = (state_q == DONE);
  assign bus.busy     = (state_q == DRAW);
  assign bus.rand_out = lfsr;

  if (VAL_W > WIDTH) begin : g_bad_val_w
    $error("card_rand_gen: card field wider than the LFSR");
  end
  if (VAL_W == WIDTH && MAX_VAL > (2**WIDTH) - 2) begin : g_bad_max_val
    $error("card_rand_gen: MAX_VAL would require the lockup pattern");
  end

endmodule

// File: tb/tb_card_rand_gen.sv
// tb/tb_card_rand_gen.sv - directed table-driven bench for card_rand_gen
module tb_card_rand_gen;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  card_rand_gen_if #(.WIDTH(4), .NUM_CARDS(4), .MAX_VAL(13)) bus ();

  card_rand_gen #(.WIDTH(4), .NUM_CARDS(4), .MAX_VAL(13)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        rst;
    logic        seed_ld;
    logic [3:0]  seed;
    logic        req;
    logic        ack;
    logic [3:0]  exp_rand;
    logic        exp_valid;
    logic        exp_busy;
    logic [15:0] exp_cards;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ld, input logic [3:0] s,
                       input logic rq, input logic ak);
    rst         = r;
    bus.seed_ld = ld;
    bus.seed    = s;
    bus.req     = rq;
    bus.ack     = ak;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] free_seq [16];
  logic [15:0] held;
  int n;

  initial begin
    free_seq = '{4'd0, 4'd1, 4'd3, 4'd7, 4'd14, 4'd13, 4'd11, 4'd6,
                 4'd12, 4'd9, 4'd2, 4'd5, 4'd10, 4'd4, 4'd8, 4'd0};

    //             rst ld seed   req ack  rand  vld bsy cards
    vecs.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'd1,  1'b0, 1'b1, 16'h0000});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd3,  1'b0, 1'b1, 16'h0001});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd7,  1'b0, 1'b1, 16'h0031});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd14, 1'b0, 1'b1, 16'h0731});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd13, 1'b0, 1'b1, 16'h0731});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd11, 1'b1, 1'b0, 16'hD731});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'd6,  1'b0, 1'b0, 16'hD731});
    vecs.push_back('{1'b0, 1'b1, 4'h6, 1'b1, 1'b0, 4'd6,  1'b0, 1'b1, 16'hD731});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd12, 1'b0, 1'b1, 16'hD736});
    vecs.push_back('{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 4'd9,  1'b0, 1'b1, 16'hD7C6});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd2,  1'b0, 1'b1, 16'hD9C6});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd5,  1'b1, 1'b0, 16'h29C6});
    vecs.push_back('{1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 16'h29C6});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd1,  1'b1, 1'b0, 16'h29C6});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'd3,  1'b1, 1'b0, 16'h29C6});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'd7,  1'b0, 1'b1, 16'h29C6});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd14, 1'b0, 1'b1, 16'h29C7});
    vecs.push_back('{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 16'h0000});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'd1,  1'b0, 1'b1, 16'h0000});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd3,  1'b0, 1'b1, 16'h0001});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd7,  1'b0, 1'b1, 16'h0031});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd14, 1'b0, 1'b1, 16'h0731});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd13, 1'b0, 1'b1, 16'h0731});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd11, 1'b1, 1'b0, 16'hD731});

    drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    check("reset_rand",  16'(bus.rand_out), 16'h0);
    check("reset_valid", 16'(bus.valid),    16'h0);
    check("reset_busy",  16'(bus.busy),     16'h0);
    check("reset_cards", bus.cards,         16'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].seed_ld, vecs[i].seed, vecs[i].req, vecs[i].ack);
      check($sformatf("v%0d_rand", i),  16'(bus.rand_out), 16'(vecs[i].exp_rand));
      check($sformatf("v%0d_valid", i), 16'(bus.valid),    16'(vecs[i].exp_valid));
      check($sformatf("v%0d_busy", i),  16'(bus.busy),     16'(vecs[i].exp_busy));
      check($sformatf("v%0d_cards", i), bus.cards,         vecs[i].exp_cards);
    end

    // Free-running period with req held low
    drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    check("free_0", 16'(bus.rand_out), 16'(free_seq[0]));
    for (int i = 1; i < 16; i++) begin
      drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      check($sformatf("free_%0d", i), 16'(bus.rand_out), 16'(free_seq[i]));
      check($sformatf("free_idle_%0d", i), 16'(bus.busy), 16'h0);
    end

    // Seeded draw with bounded wait, then a held DONE with ignored req pulses
    drive(1'b0, 1'b1, 4'h6, 1'b1, 1'b0);
    n = 0;
    while (!bus.valid && n < 40) begin
      drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      n++;
    end
    check("seed_latency", 16'(n), 16'd4);
    check("seed_cards", bus.cards, 16'h29C6);
    held = 16'h29C6;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 4'h0, 1'(i % 2), 1'b0);
      check($sformatf("hold_valid_%0d", i), 16'(bus.valid), 16'h1);
      check($sformatf("hold_cards_%0d", i), bus.cards, held);
    end
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    check("rearm_busy",  16'(bus.busy),  16'h1);
    check("rearm_valid", 16'(bus.valid), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
